// File: rtl/video_pkg.sv
// Shared video types: pattern modes, 1-bit colour masks and mode decoding.
// Used by the pattern generator and by video_sync_gen consumers.
package video_pkg;

    typedef enum logic [2:0] {
        CROSS  = 3'd0,
        GRID   = 3'd1,
        BARS   = 3'd2,
        CHECK  = 3'd3,
        RAMP   = 3'd4,
        MOVBAR = 3'd5
    } mode_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb1_t;

    localparam rgb1_t C_WHITE = 3'b111;
    localparam rgb1_t C_BLACK = 3'b000;
    localparam rgb1_t C_BLUE  = 3'b001;

    // Codes 6 and 7 are not patterns; they fall back to the crosshair.
    function automatic mode_e mode_decode(input logic [2:0] m);
        return (m > 3'd5) ? CROSS : mode_e'(m);
    endfunction

endpackage

// File: rtl/video_bar_index.sv
// Maps a horizontal position to one of eight equal colour-bar indices
// using a comparator chain against the bar boundaries.
module video_bar_index #(
    parameter int HCW      = 12,
    parameter int H_ACTIVE = 640
) (
    input  logic [HCW-1:0] h_cnt_i,
    output logic [2:0]     idx_o
);

    localparam int BW = H_ACTIVE / 8;

    always_comb begin
        idx_o = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt_i >= HCW'(k * BW)) begin
                idx_o = 3'(k);
            end
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Multi-mode test-pattern generator: mode latch, moving-bar position and
// a two-stage pixel pipeline with delay-matched syncs.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int HCW       = 12,
    parameter int VCW       = 12,
    parameter int VW        = 8,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int GRID_LOG2 = 5,
    parameter int CHK_LOG2  = 4,
    parameter int BAR_W     = 16,
    parameter int BAR_STEP  = 4
) (
    input  logic           clk,
    input  logic           clk_en,
    input  logic           rst,
    input  logic [2:0]     mode_in,
    input  logic [HCW-1:0] h_cnt,
    input  logic [VCW-1:0] v_cnt,
    input  logic           active,
    input  logic           a_start,
    input  logic           h_sync,
    input  logic           v_sync,
    output logic           vid_hsync,
    output logic           vid_vsync,
    output logic           vid_vld,
    output logic [VW-1:0]  vid_r,
    output logic [VW-1:0]  vid_g,
    output logic [VW-1:0]  vid_b,
    output logic [2:0]     mode_cur
);

    typedef struct packed {
        logic [VW-1:0] r;
        logic [VW-1:0] g;
        logic [VW-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic          act;
        logic          hs;
        logic          vs;
        mode_e         mode;
        logic          hit;
        logic [2:0]    idx;
        logic [VW-1:0] ramp_r;
        logic [VW-1:0] ramp_g;
    } s1_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vld;
        rgb_t rgb;
    } s2_t;

    function automatic rgb_t expand(input rgb1_t c);
        rgb_t o;
        o.r = {VW{c.r}};
        o.g = {VW{c.g}};
        o.b = {VW{c.b}};
        return o;
    endfunction

    mode_e          mode_q, mode_d;
    logic [HCW-1:0] pos_q, pos_d;
    s1_t            s1_q, s1_d;
    s2_t            s2_q, s2_d;

    logic [HCW:0]   pos_sum;
    logic [HCW-1:0] pos_nxt;
    logic [HCW:0]   bar_off;
    logic [2:0]     bar_idx;
    logic           hit_cross;
    logic           hit_grid;
    logic           hit_chk;
    logic           hit_bar;
    rgb_t           rgb;

    // Mode and bar position switch on the a_start pixel itself, so the
    // frame that is starting already uses the new values.
    assign pos_sum = {1'b0, pos_q} + (HCW+1)'(BAR_STEP);
    assign pos_nxt = (pos_sum >= (HCW+1)'(H_ACTIVE))
                   ? HCW'(pos_sum - (HCW+1)'(H_ACTIVE))
                   : HCW'(pos_sum);

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        if (a_start) begin
            mode_d = mode_decode(mode_in);
            pos_d  = pos_nxt;
        end
    end

    video_bar_index #(
        .HCW      (HCW),
        .H_ACTIVE (H_ACTIVE)
    ) u_bar_index (
        .h_cnt_i (h_cnt),
        .idx_o   (bar_idx)
    );

    assign hit_cross = (v_cnt == VCW'(0))
                    || (v_cnt == VCW'(V_ACTIVE / 2))
                    || (v_cnt == VCW'(V_ACTIVE - 1))
                    || (h_cnt == HCW'(0))
                    || (h_cnt == HCW'(H_ACTIVE / 2))
                    || (h_cnt == HCW'(H_ACTIVE - 1));

    assign hit_grid = (h_cnt[GRID_LOG2-1:0] == '0)
                   || (v_cnt[GRID_LOG2-1:0] == '0)
                   || (h_cnt == HCW'(H_ACTIVE - 1))
                   || (v_cnt == VCW'(V_ACTIVE - 1));

    assign hit_chk = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];

    // Distance from the bar start, wrapped modulo the active width.
    assign bar_off = (h_cnt >= pos_d)
                   ? {1'b0, h_cnt} - {1'b0, pos_d}
                   : {1'b0, h_cnt} + (HCW+1)'(H_ACTIVE) - {1'b0, pos_d};
    assign hit_bar = bar_off < (HCW+1)'(BAR_W);

    always_comb begin
        s1_d     = '0;
        s1_d.act = active;
        s1_d.hs  = h_sync;
        s1_d.vs  = v_sync;
        if (active) begin
            s1_d.mode   = mode_d;
            s1_d.idx    = bar_idx;
            s1_d.ramp_r = h_cnt[VW-1:0];
            s1_d.ramp_g = v_cnt[VW-1:0];
            unique case (mode_d)
                CROSS:   s1_d.hit = hit_cross;
                GRID:    s1_d.hit = hit_grid;
                CHECK:   s1_d.hit = hit_chk;
                MOVBAR:  s1_d.hit = hit_bar;
                default: s1_d.hit = 1'b0;
            endcase
        end
    end

    always_comb begin
        rgb = '0;
        unique case (s1_q.mode)
            BARS: begin
                rgb = expand({~s1_q.idx[1], ~s1_q.idx[2], ~s1_q.idx[0]});
            end
            RAMP: begin
                rgb.r = s1_q.ramp_r;
                rgb.g = s1_q.ramp_g;
                rgb.b = s1_q.ramp_r ^ s1_q.ramp_g;
            end
            MOVBAR:  rgb = expand(s1_q.hit ? C_WHITE : C_BLUE);
            default: rgb = expand(s1_q.hit ? C_WHITE : C_BLACK);
        endcase
        s2_d     = '0;
        s2_d.hs  = s1_q.hs;
        s2_d.vs  = s1_q.vs;
        s2_d.vld = s1_q.act;
        s2_d.rgb = s1_q.act ? rgb : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= CROSS;
            pos_q  <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else if (clk_en) begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
        end
    end

    assign vid_hsync = s2_q.hs;
    assign vid_vsync = s2_q.vs;
    assign vid_vld   = s2_q.vld;
    assign vid_r     = s2_q.rgb.r;
    assign vid_g     = s2_q.rgb.g;
    assign vid_b     = s2_q.rgb.b;
    assign mode_cur  = mode_q;

endmodule
